// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t       : responder FSM states
//   BASE_WORD_DEF : default word address of storage word 0 (byte 0x80000000)
//   MMIO_TX_WORD  : word address of the UART transmit register (byte 0xA0000000)
//   CNT_W         : width of the access-latency down-counter
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [29:0] BASE_WORD_DEF = 30'h20000000;
    localparam logic [29:0] MMIO_TX_WORD  = 30'h28000000;
    localparam int          CNT_W         = 4;

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder.
// Byte-lane write enables, asynchronous read, no reset (contents persist).
// Ports:
//   clk   : write clock
//   we    : write strobe
//   be    : byte-lane enables, bit i writes wdata[8i+7:8i]
//   addr  : word index (shared by read and write)
//   wdata : write data, lane-aligned
//   rdata : combinational read of the word at addr
module dmem_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data port.
// Accepts one word-addressed read/write at a time on a valid/ready request
// channel, waits a fixed LATENCY, performs the access exactly once when the
// response is raised, and holds the response until rsp_ready.
// Accesses outside [BASE_WORD, BASE_WORD + 2**DEPTH_LOG2) answer with rsp_err.
// Ports:
//   clk, rst                : clock (rising edge), asynchronous active-high reset
//   req_valid / req_ready   : request handshake
//   req_wen, req_addr       : 1 = write; word address (byte address [31:2])
//   req_mask, req_wdata     : byte-lane enables and lane-aligned write data
//   rsp_valid / rsp_ready   : response handshake
//   rsp_rdata, rsp_err      : read data (0 for writes/errors), window error
// Optional build macro DMEM_MMIO_UART_EN adds a UART transmit register at
// word MMIO_TX_WORD with outputs mmio_tx_valid (1-cycle pulse) and
// mmio_tx_data; without it that word is simply out of range.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [29:0] BASE_WORD  = BASE_WORD_DEF,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [29:0] req_addr,
    input  logic [3:0]  req_mask,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_MMIO_UART_EN
    ,
    output logic        mmio_tx_valid,
    output logic [7:0]  mmio_tx_data
`endif
);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic        wen_q;
    logic [29:0] addr_q;
    logic [3:0]  mask_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic        enter_resp;
    logic        acc_wen;
    logic [29:0] acc_addr;
    logic [3:0]  acc_mask;
    logic [31:0] acc_wdata;
    logic [29:0] diff;
    logic        in_range;
    logic        is_mmio;
    logic        arr_we;
    logic [31:0] arr_rdata;
    logic [31:0] nxt_rdata;
    logic        nxt_err;

    assign accept = (state == IDLE) && req_ready && req_valid;

    // With LATENCY=1 the access executes on the accept edge itself, before the
    // request fields have been latched, so the live request is used instead.
    assign enter_resp = ((state == IDLE) && accept && (LATENCY == 1)) ||
                        ((state == WAIT) && (cnt == CNT_W'(1)));

    assign acc_wen   = (state == IDLE) ? req_wen   : wen_q;
    assign acc_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign acc_mask  = (state == IDLE) ? req_mask  : mask_q;
    assign acc_wdata = (state == IDLE) ? req_wdata : wdata_q;

    // 30-bit wraparound offset: addresses below the base wrap high and fail.
    assign diff     = acc_addr - BASE_WORD;
    assign in_range = ((diff >> DEPTH_LOG2) == '0);

`ifdef DMEM_MMIO_UART_EN
    assign is_mmio = (acc_addr == MMIO_TX_WORD);
`else
    assign is_mmio = 1'b0;
`endif

    assign arr_we = enter_resp && acc_wen && in_range && !is_mmio;

    dmem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .be   (acc_mask),
        .addr (diff[DEPTH_LOG2-1:0]),
        .wdata(acc_wdata),
        .rdata(arr_rdata)
    );

    always_comb begin
        nxt_rdata = '0;
        nxt_err   = 1'b1;
        if (is_mmio) begin
            nxt_err = 1'b0;
        end else if (in_range) begin
            nxt_err = 1'b0;
            if (!acc_wen) begin
                nxt_rdata = arr_rdata;
            end
        end
    end

    // Request fields are data only; they are meaningful once accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            wen_q   <= req_wen;
            addr_q  <= req_addr;
            mask_q  <= req_mask;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef DMEM_MMIO_UART_EN
            mmio_tx_valid <= 1'b0;
            mmio_tx_data  <= '0;
`endif
        end else begin
`ifdef DMEM_MMIO_UART_EN
            mmio_tx_valid <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        cnt       <= CNT_W'(LATENCY - 1);
                        state     <= WAIT;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // The access result is captured once, on the edge entering RESP.
            if (enter_resp) begin
                state     <= RESP;
                rsp_valid <= 1'b1;
                rsp_rdata <= nxt_rdata;
                rsp_err   <= nxt_err;
`ifdef DMEM_MMIO_UART_EN
                if (is_mmio && acc_wen && acc_mask[0]) begin
                    mmio_tx_valid <= 1'b1;
                    mmio_tx_data  <= acc_wdata[7:0];
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (default parameters, LATENCY=2).
// A transaction-level model predicts outputs every cycle from handshake
// timestamps and a word array; directed cases pin literal values.
module tb_dmem_responder;

    localparam int          LAT  = 2;
    localparam logic [29:0] BASE = 30'h20000000;
    localparam logic [29:0] MMIO = 30'h28000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [29:0] req_addr = '0;
    logic [3:0]  req_mask = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef DMEM_MMIO_UART_EN
    logic        mmio_tx_valid;
    logic [7:0]  mmio_tx_data;
`endif

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_LOG2(10),
        .BASE_WORD (BASE),
        .LATENCY   (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wen  (req_wen),
        .req_addr (req_addr),
        .req_mask (req_mask),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
`ifdef DMEM_MMIO_UART_EN
        ,
        .mmio_tx_valid(mmio_tx_valid),
        .mmio_tx_data (mmio_tx_data)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mmem   [1024];
    bit          mknown [1024];
    bit          m_busy = 0;
    int unsigned m_edge = 0;
    int unsigned m_due  = 0;
    bit          m_wen;
    logic [29:0] m_addr;
    logic [3:0]  m_mask;
    logic [31:0] m_wdata;

    bit          e_ready  = 0;
    bit          e_valid  = 0;
    bit          e_err    = 0;
    bit          e_rknown = 1;
    logic [31:0] e_rdata  = '0;
    bit          e_txv    = 0;
    logic [7:0]  e_txd    = '0;

    task automatic model_access();
        int unsigned off;
        off      = int'((m_addr - BASE) & 30'h3FFFFFFF);
        e_valid  = 1;
        e_rdata  = '0;
        e_err    = 0;
        e_rknown = 1;
`ifdef DMEM_MMIO_UART_EN
        if (m_addr == MMIO) begin
            if (m_wen && m_mask[0]) begin
                e_txv = 1;
                e_txd = m_wdata[7:0];
            end
        end else
`endif
        if (off < 1024) begin
            if (m_wen) begin
                for (int i = 0; i < 4; i++)
                    if (m_mask[i]) mmem[off][8*i +: 8] = m_wdata[8*i +: 8];
                if (m_mask == 4'hF) mknown[off] = 1;
            end else begin
                e_rdata  = mmem[off];
                e_rknown = mknown[off];
            end
        end else begin
            e_err = 1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   = 0;
            e_ready  = 0;
            e_valid  = 0;
            e_err    = 0;
            e_rdata  = '0;
            e_rknown = 1;
            e_txv    = 0;
            e_txd    = '0;
        end else begin
            m_edge++;
            e_txv = 0;
            if (m_busy) begin
                if (e_valid && rsp_ready) begin
                    e_valid  = 0;
                    e_rdata  = '0;
                    e_err    = 0;
                    e_rknown = 1;
                    e_ready  = 1;
                    m_busy   = 0;
                end
            end else if (e_ready && req_valid) begin
                m_busy  = 1;
                m_due   = m_edge + LAT - 1;
                m_wen   = req_wen;
                m_addr  = req_addr;
                m_mask  = req_mask;
                m_wdata = req_wdata;
                e_ready = 0;
            end else begin
                e_ready = 1;
            end
            if (m_busy && !e_valid && m_edge == m_due) model_access();
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("req_ready", 32'(req_ready), 32'(e_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(e_valid));
        check("rsp_err", 32'(rsp_err), 32'(e_err));
        if (e_rknown) check("rsp_rdata", rsp_rdata, e_rdata);
`ifdef DMEM_MMIO_UART_EN
        check("mmio_tx_valid", 32'(mmio_tx_valid), 32'(e_txv));
        check("mmio_tx_data", 32'(mmio_tx_data), 32'(e_txd));
`endif
    end

    int unsigned dut_hs = 0;
    always @(posedge clk) if (!rst && rsp_valid && rsp_ready) dut_hs++;

`ifdef DMEM_MMIO_UART_EN
    int         txv_cnt = 0;
    logic [7:0] txd_last = '0;
    always @(negedge clk) if (mmio_tx_valid) begin
        txv_cnt++;
        txd_last = mmio_tx_data;
    end
`endif

    // ---------------- stimulus ----------------
    task automatic txn(input bit wen, input logic [29:0] addr, input logic [3:0] mask,
                       input logic [31:0] wdata, input int hold, input bit early,
                       output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1;
        req_wen   = wen;
        req_addr  = addr;
        req_mask  = mask;
        req_wdata = wdata;
        rsp_ready = early;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("accept_timeout", 32'(req_ready), 1);
        @(negedge clk);
        lat       = 1;
        req_valid = 1'($urandom_range(0, 1));
        req_wen   = 1'($urandom_range(0, 1));
        req_addr  = 30'($urandom);
        req_mask  = 4'($urandom);
        req_wdata = $urandom;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 1);
        rd = rsp_rdata;
        er = rsp_err;
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("bp_valid", 32'(rsp_valid), 1);
                check("bp_rdata", rsp_rdata, rd);
                check("bp_err", 32'(rsp_err), 32'(er));
                check("bp_req_ready", 32'(req_ready), 0);
            end
            rsp_ready = 1;
        end
        @(negedge clk);
        req_valid = 0;
        rsp_ready = 0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int unsigned hs0;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, run did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1;
        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 0);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        check("reset_rsp_err", 32'(rsp_err), 0);
        #2 rst = 0;
        #1 check("release_req_ready_low", 32'(req_ready), 0);
        @(negedge clk);
        check("release_req_ready_high", 32'(req_ready), 1);

        // full-word write then read
        txn(1, BASE, 4'hF, 32'hDEADBEEF, 0, 1, rd, er, lat);
        check("wr_lat", 32'(lat), 2);
        check("wr_err", 32'(er), 0);
        check("wr_rdata", rd, 0);
        txn(0, BASE, 4'h0, 32'h0, 0, 1, rd, er, lat);
        check("rd_lat", 32'(lat), 2);
        check("rd_data", rd, 32'hDEADBEEF);
        check("rd_err", 32'(er), 0);

        // single-lane write
        txn(1, BASE, 4'b0100, 32'h00AA0000, 0, 1, rd, er, lat);
        txn(0, BASE, 4'h0, 32'h0, 0, 0, rd, er, lat);
        check("byte_rd_data", rd, 32'hDEAABEEF);

        // backpressure
        hs0 = dut_hs;
        txn(0, BASE, 4'h0, 32'h0, 5, 0, rd, er, lat);
        check("bp_rd_data", rd, 32'hDEAABEEF);
        check("bp_once", dut_hs - hs0, 1);

        // out of range
        txn(0, 30'h1FFFFFFF, 4'hF, 32'h0, 0, 1, rd, er, lat);
        check("oor_low_err", 32'(er), 1);
        check("oor_low_rdata", rd, 0);
        txn(1, 30'h20000400, 4'hF, 32'hCAFEF00D, 0, 1, rd, er, lat);
        check("oor_high_err", 32'(er), 1);
        check("oor_high_rdata", rd, 0);
        txn(0, BASE, 4'h0, 32'h0, 0, 1, rd, er, lat);
        check("oor_idx0_unchanged", rd, 32'hDEAABEEF);

        // reset in the WAIT cycle of a write
        @(negedge clk);
        req_valid = 1; req_wen = 1; req_addr = BASE; req_mask = 4'hF;
        req_wdata = 32'h12345678; rsp_ready = 1;
        while (!req_ready) @(negedge clk);
        @(negedge clk);
        req_valid = 0;
        check("midop_in_wait", 32'(rsp_valid), 0);
        #2 rst = 1;
        #1 check("midop_rst_valid", 32'(rsp_valid), 0);
        repeat (3) begin
            @(negedge clk);
            check("midop_hold_valid", 32'(rsp_valid), 0);
        end
        #2 rst = 0;
        rsp_ready = 0;
        txn(0, BASE, 4'h0, 32'h0, 0, 1, rd, er, lat);
        check("midop_prior_value", rd, 32'hDEAABEEF);

        // UART register word
        txn(1, MMIO, 4'h1, 32'h00000041, 0, 1, rd, er, lat);
`ifdef DMEM_MMIO_UART_EN
        check("mmio_err", 32'(er), 0);
        check("mmio_lat", 32'(lat), 2);
        check("mmio_pulses", 32'(txv_cnt), 1);
        check("mmio_data", 32'(txd_last), 32'h41);
`else
        check("mmio_absent_err", 32'(er), 1);
`endif

        // preload the random address pool so every read is predictable
        for (int i = 0; i < 16; i++) begin
            int idx;
            idx = (i < 8) ? i : 1008 + i;
            txn(1, BASE + 30'(idx), 4'hF, $urandom, 0, 1, rd, er, lat);
        end

        // randomized traffic
        for (int t = 0; t < 250; t++) begin
            logic [29:0] a;
            int          sel;
            sel = $urandom_range(0, 7);
            if (sel < 6) begin
                a = (sel < 3) ? BASE + 30'($urandom_range(0, 7))
                              : BASE + 30'($urandom_range(1016, 1023));
            end else begin
                case ($urandom_range(0, 5))
                    0: a = BASE - 30'd1;
                    1: a = BASE + 30'd1024;
                    2: a = 30'h0;
                    3: a = 30'h3FFFFFFF;
                    4: a = MMIO;
                    default: a = BASE + 30'd2048;
                endcase
            end
            txn(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom,
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), rd, er, lat);
            check("rand_lat", 32'(lat), 2);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data port. It serves word-addressed read and write requests with byte-lane masks.
- Sits between the execute/load-store path and on-chip data storage.
- Adds a valid/ready request channel, a valid/ready response channel and a fixed, parameterised access latency, so the core can be moved off single-cycle memory.
- Also flags accesses outside its window as errors.

Parameters:
- DEPTH_LOG2, 10, storage depth in 32-bit words (1024 words).
- BASE_WORD, 30'h20000000, word address of the first storage word (byte address 0x80000000).
- LATENCY, 2, cycles from request acceptance to first rsp_valid; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  30  word address (byte address [31:2]).
- req_mask  in  4  byte-lane write enables; bit i selects wdata[8i+7:8i]; ignored on reads.
- req_wdata  in  32  write data, already lane-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  read data, full word; 0 for writes and errors.
- rsp_err  out  1  address outside the window (or not a mapped MMIO access).

Behaviour:
- Reset values: req_ready=0 while rst is high, then 1 from the first clock after release. rsp_valid=0, rsp_rdata=0, rsp_err=0. Storage contents are NOT reset.
- States:
  - IDLE: req_ready=1, rsp_valid=0.
  - WAIT: req_ready=0, rsp_valid=0; a down-counter runs.
  - RESP: req_ready=0, rsp_valid=1.
- Accept: in IDLE, req_valid=1 at an edge is a handshake. Latch wen, addr, mask and wdata. Load cnt=LATENCY-1.
  - LATENCY=1: go directly to RESP.
  - Otherwise: go to WAIT.
- WAIT: decrement cnt each cycle. When cnt reaches 1, the next state is RESP. If the accept happens in cycle T, rsp_valid is first high in cycle T+LATENCY.
- On the transition into RESP, the access executes exactly once:
  - In range means (addr - BASE_WORD) < 2**DEPTH_LOG2, using 30-bit unsigned wraparound subtraction. The storage index is the low DEPTH_LOG2 bits of the difference.
  - Read, in range: rsp_rdata = the stored word.
  - Write, in range: update only the lanes whose mask bit is 1. rsp_rdata=0. mask=0 is legal: nothing changes, but a response is still produced.
  - Out of range: rsp_err=1, rsp_rdata=0, storage untouched.
- RESP: rsp_valid, rsp_rdata and rsp_err stay stable until rsp_ready=1. Then go to IDLE, and the next cycle clears rsp_valid, rsp_rdata and rsp_err to 0. rsp_ready may be held high in advance.
- No request is accepted in the RESP handshake cycle. Peak throughput is one transaction per LATENCY+1 cycles.
- Requester inputs are don't-care outside IDLE.
- Read-after-write to the same word in consecutive transactions returns the new data.
- Reset mid-transaction: the transaction is dropped immediately and outputs return to reset values. A write that had not yet reached RESP entry leaves storage unchanged.

Optional Feature:
- Macro DMEM_MMIO_UART_EN.
- Defined: adds ports mmio_tx_valid (out, 1) and mmio_tx_data (out, 8), both reset to 0.
  - A write to word 30'h28000000 (byte address 0xA0000000) with req_mask[0]=1 executes at RESP entry: mmio_tx_data=wdata[7:0], mmio_tx_valid pulses high for exactly one cycle. rsp_err=0.
  - A read of that word returns 0 with rsp_err=0.
  - A write with mask[0]=0 is a no-op with rsp_err=0.
- Undefined: the ports are absent and that address behaves as out of range (rsp_err=1).

Decomposition:
- Package dmem_pkg holds:
  - State enum {IDLE, WAIT, RESP}.
  - BASE_WORD default.
  - MMIO_TX_WORD = 30'h28000000.
  - The latency counter width (4).
- One sub-module, dmem_array: word storage with a 4-bit byte write enable, an asynchronous read port and no reset. The responder FSM drives it only at RESP entry.

Test Plan:
- Reset release, then read addr 30'h20000000 after writing 32'hDEADBEEF with mask 4'hF (LATENCY=2). Required: accept at T, rsp_valid at T+2, rsp_rdata=32'hDEADBEEF, rsp_err=0.
- Byte write: mask 4'b0100, wdata 32'h00AA0000 to the same word, then read. Required: rsp_rdata=32'hDEAABEEF.
- Backpressure: hold rsp_ready=0 for 5 cycles during a response. Required: rsp_valid, rsp_rdata and rsp_err stable throughout, req_ready=0; the word is returned exactly once after rsp_ready=1.
- Out of range: read 30'h1FFFFFFF and write 30'h20000400 (with DEPTH_LOG2=10). Required: rsp_err=1, rsp_rdata=0, and a subsequent read of index 0 is unchanged.
- Reset mid-op: assert rst in the WAIT cycle of a write of 32'h12345678. Required: rsp_valid never rises, and a later read of that word returns the prior value.
- With DMEM_MMIO_UART_EN defined: write 32'h00000041, mask 4'h1, to 30'h28000000. Required: one-cycle mmio_tx_valid with mmio_tx_data=8'h41 at T+2, rsp_err=0. Without the macro: rsp_err=1.
